array_loader_16x8: RTL and testbench
====================================

# array_loader_16x8

Upstream stage of the 16-entry min/max finder. Accepts a stream of 8-bit unsigned samples over a valid/ready handshake and fills a 16×8 register array. When the array is full it pulses `Start` to the finder. It then freezes the array and serves the finder's combinational reads until the finder reports done, after which it reopens for the next batch.

## Interface
- `WIDTH`, 8, sample width in bits.
- `DEPTH`, 16, array entries (fixed at 16; address width 4).
- `Clk`  in  1  single clock; all state changes on posedge.
- `Reset`  in  1  synchronous, active-high.
- `Din`  in  8  sample to be written.
- `Din_valid`  in  1  `Din` is valid this cycle.
- `Din_ready`  out  1  loader can accept; a beat transfers when `Din_valid && Din_ready` at posedge.
- `Rd_addr`  in  4  finder's read index (its `I`).
- `Rd_data`  out  8  `M[Rd_addr]`; combinational (asynchronous) read.
- `Fin_idle`  in  1  finder is in INI (its `Qi`).
- `Fin_done`  in  1  finder is in DONE (its `Qd`).
- `Start`  out  1  start request to finder.
- `Count`  out  5  samples written in current batch, 0..16.
- `Batch_cnt`  out  8  completed batches (finder done seen), wraps 255→0.
- `Qf`, `Qs`, `Qw`  out  1 each  one-hot state: FILL, STRT, WAIT.

## Operation
- States, one-hot 3-bit: FILL=3'b001, STRT=3'b010, WAIT=3'b100; `{Qw,Qs,Qf}` = state.
- Reset (sync, any state, mid-batch included):
  - state←FILL, `Count`←0, `Batch_cnt`←0.
  - Array contents are not cleared; they are undefined until written.
- FILL:
  - `Din_ready`=1.
  - On accept: `M[Count[3:0]]`←`Din`, `Count`←`Count`+1.
  - Accept while `Count`==15 → `Count`←16, state←STRT.
  - `Fin_done`/`Fin_idle` are ignored.
- STRT:
  - `Din_ready`=0.
  - `Start`=`Fin_idle` (combinational, this state only).
  - `Fin_idle`=1 → state←WAIT. Otherwise stay, `Start` low.
- WAIT:
  - `Din_ready`=0, `Start`=0. Array frozen.
  - `Fin_done`=1 → state←FILL, `Count`←0, `Batch_cnt`←`Batch_cnt`+1.
- `Start` and `Din_ready` are decoded from state only (plus `Fin_idle` for `Start`). They never depend on `Din_valid`.
- Writes occur only in FILL. No read/write collision is possible while the finder is running.
- `Rd_data` is valid in every state. In FILL, a read of the address being written returns the old value until the posedge.
- `Din_valid` outside FILL is not an error. The beat is simply not accepted; the source holds it.
- Width: `Count` is 5 bits and never exceeds 16. `Batch_cnt` is modulo 256.

## Timing
- Reset values: `Din_ready`=1, `Start`=0, `Count`=0, `Batch_cnt`=0, `Qf`=1, `Qs`=0, `Qw`=0.
- Back-to-back beats: 1 sample/cycle in FILL, so the minimum fill time is 16 cycles.
- 16th accept at edge N → STRT during cycle N+1.
  - `Start`=1 in cycle N+1 if `Fin_idle`=1.
  - Finder samples `Start` at edge N+2 and leaves INI.
  - Loader enters WAIT at the same edge N+2.
- `Start` is high for exactly one cycle per batch.
- `Fin_done` high at edge D → FILL at D+1, with `Din_ready`=1 in that cycle.
- Finder DONE lasts one cycle, so `Batch_cnt` increments exactly once per batch.
- `Fin_idle` low in STRT stalls indefinitely with no lost data; `Start` rises in the first cycle `Fin_idle` is high.

## Test plan
- Reset, then 16 consecutive beats 0x10,0x20,…,0xF0,0x05 → `Count`=16, STRT the next cycle, one-cycle `Start` (finder idle), WAIT. `Rd_addr`=0→`Rd_data`=0x10, `Rd_addr`=15→0x05.
- In WAIT, hold `Din_valid`=1 with 0xAA for 20 cycles → `Din_ready`=0 throughout, array unchanged (`Rd_addr`=3 still reads 0x40).
- Hold `Fin_idle`=0 for 5 cycles after the fill → remain in STRT with `Start`=0. Raise `Fin_idle` → `Start`=1 that cycle, WAIT the next.
- With the real finder attached, load 0x7F,0x03,0xC8,… (max 0xC8, min 0x03) → finder reports Max=0xC8, Min=0x03; `Fin_done` → FILL, `Batch_cnt`=1, `Count`=0.
- Gapped valid (1 of 3 cycles) for 9 beats, then sync `Reset` → FILL, `Count`=0, `Batch_cnt`=0. A fresh 16-beat batch completes normally.
- Run 256 batches → `Batch_cnt` wraps to 0.

Source files
------------

// File: rtl/array_loader_16x8.sv
// Input stage of the 16-entry min/max finder: fills a 16x8 array from a valid/ready stream,
// hands it to the finder with a Start pulse, and holds it frozen until the finder is done.
module array_loader_16x8 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  output logic             Din_ready,
  input  logic [3:0]       Rd_addr,
  output logic [WIDTH-1:0] Rd_data,
  input  logic             Fin_idle,
  input  logic             Fin_done,
  output logic             Start,
  output logic [4:0]       Count,
  output logic [7:0]       Batch_cnt,
  output logic             Qf,
  output logic             Qs,
  output logic             Qw
);

  localparam logic [4:0] LastIdx = 5'(DEPTH - 1);

  typedef enum logic [2:0] {
    StFill = 3'b001,
    StStrt = 3'b010,
    StWait = 3'b100
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             accept;

  assign accept = (state == StFill) && Din_valid && !Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= StFill;
      Count     <= 5'd0;
      Batch_cnt <= 8'd0;
    end else begin
      unique case (state)
        StFill: begin
          if (Din_valid) begin
            Count <= Count + 5'd1;
            if (Count == LastIdx) state <= StStrt;
          end
        end
        StStrt: begin
          if (Fin_idle) state <= StWait;
        end
        StWait: begin
          if (Fin_done) begin
            state     <= StFill;
            Count     <= 5'd0;
            Batch_cnt <= Batch_cnt + 8'd1;
          end
        end
        default: state <= StFill;
      endcase
    end
  end

  // Storage is deliberately not reset; entries are undefined until written.
  always_ff @(posedge Clk) begin
    if (accept) mem[Count[3:0]] <= Din;
  end

  assign Rd_data      = mem[Rd_addr];
  assign Din_ready    = (state == StFill);
  assign Start        = (state == StStrt) && Fin_idle;
  assign {Qw, Qs, Qf} = state;

endmodule

// File: tb/tb_array_loader_16x8.sv
// Directed bench for array_loader_16x8 with a cycle-level reference model and a stand-in finder.
module tb_array_loader_16x8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] Din = 8'h00;
  logic       Din_valid = 1'b0;
  logic       Din_ready;
  logic [3:0] Rd_addr = 4'd0;
  logic [7:0] Rd_data;
  logic       Fin_idle = 1'b1;
  logic       Fin_done = 1'b0;
  logic       Start;
  logic [4:0] Count;
  logic [7:0] Batch_cnt;
  logic       Qf, Qs, Qw;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  array_loader_16x8 #(.WIDTH(8), .DEPTH(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Din       (Din),
    .Din_valid (Din_valid),
    .Din_ready (Din_ready),
    .Rd_addr   (Rd_addr),
    .Rd_data   (Rd_data),
    .Fin_idle  (Fin_idle),
    .Fin_done  (Fin_done),
    .Start     (Start),
    .Count     (Count),
    .Batch_cnt (Batch_cnt),
    .Qf        (Qf),
    .Qs        (Qs),
    .Qw        (Qw)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a batch is "filling" until 16 samples are stored, then "handed over"
  // until the finder is seen idle, then "in use" until the finder reports done.
  int         m_count = 0;
  bit         m_started = 1'b0;
  int         m_batch = 0;
  bit         m_live = 1'b0;
  logic [7:0] m_mem [16];
  bit         m_vld [16];

  always @(posedge Clk) begin
    if (Reset) begin
      m_live    = 1'b1;
      m_count   = 0;
      m_started = 1'b0;
      m_batch   = 0;
      foreach (m_vld[i]) m_vld[i] = 1'b0;
    end else if (m_live) begin
      if (m_count < 16) begin
        if (Din_valid) begin
          m_mem[m_count] = Din;
          m_vld[m_count] = 1'b1;
          m_count++;
        end
      end else if (!m_started) begin
        if (Fin_idle) m_started = 1'b1;
      end else if (Fin_done) begin
        m_count   = 0;
        m_started = 1'b0;
        m_batch   = (m_batch + 1) % 256;
      end
    end
  end

  always @(negedge Clk) begin
    if (m_live) begin
      check("din_ready", Din_ready, (m_count < 16));
      check("start", Start, (m_count == 16 && !m_started && Fin_idle));
      check("count", Count, m_count);
      check("batch_cnt", Batch_cnt, m_batch);
      check("state", {Qw, Qs, Qf}, {m_started, (m_count == 16 && !m_started), (m_count < 16)});
      if (m_vld[Rd_addr]) check("rd_data", Rd_data, m_mem[Rd_addr]);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    int b = 0;
    Din       = d;
    Din_valid = 1'b1;
    while (Din_ready !== 1'b1 && b < 100) begin
      tick();
      b++;
    end
    check("push_ready", Din_ready, 1);
    tick();
  endtask

  task automatic fill(input logic [7:0] d [16]);
    for (int i = 0; i < 16; i++) push(d[i]);
    Din_valid = 1'b0;
  endtask

  task automatic wait_start();
    int b = 0;
    Fin_idle = 1'b1;
    while (Start !== 1'b1 && b < 100) begin
      tick();
      b++;
    end
    check("start_seen", Start, 1);
    tick();
    Fin_idle = 1'b0;
  endtask

  // Stand-in finder: scans all 16 entries, then pulses done for one cycle.
  task automatic finder_scan(output logic [7:0] mn, output logic [7:0] mx);
    mn = 8'hFF;
    mx = 8'h00;
    for (int i = 0; i < 16; i++) begin
      Rd_addr = 4'(i);
      #1;
      if (Rd_data < mn) mn = Rd_data;
      if (Rd_data > mx) mx = Rd_data;
      tick();
    end
    Fin_done = 1'b1;
    tick();
    Fin_done = 1'b0;
    Fin_idle = 1'b1;
    check("refill_ready", Din_ready, 1);
    check("refill_count", Count, 0);
  endtask

  task automatic run_batch(input logic [7:0] d [16], output logic [7:0] mn,
                           output logic [7:0] mx);
    fill(d);
    wait_start();
    finder_scan(mn, mx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] d [16];
    logic [7:0] mn, mx;

    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_ready", Din_ready, 1);
    check("rst_start", Start, 0);
    check("rst_count", Count, 0);
    check("rst_batch", Batch_cnt, 0);
    check("rst_state", {Qw, Qs, Qf}, 3'b001);

    // Batch 1: 0x10..0xF0, 0x05 with the finder idle.
    for (int i = 0; i < 15; i++) d[i] = 8'((i + 1) * 16);
    d[15] = 8'h05;
    fill(d);
    check("t1_count", Count, 16);
    check("t1_strt", {Qw, Qs, Qf}, 3'b010);
    check("t1_start", Start, 1);
    tick();
    Fin_idle = 1'b0;
    check("t1_wait", {Qw, Qs, Qf}, 3'b100);
    check("t1_start_low", Start, 0);
    Rd_addr = 4'd0;
    #1;
    check("t1_rd0", Rd_data, 8'h10);
    Rd_addr = 4'd15;
    #1;
    check("t1_rd15", Rd_data, 8'h05);

    // Source keeps offering 0xAA while the array is frozen.
    tick();
    Din       = 8'hAA;
    Din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("wait_ready_low", Din_ready, 0);
      tick();
    end
    Din_valid = 1'b0;
    Rd_addr   = 4'd3;
    #1;
    check("wait_rd3", Rd_data, 8'h40);
    finder_scan(mn, mx);
    check("t1_max", mx, 8'hF0);
    check("t1_min", mn, 8'h05);
    check("t1_batch", Batch_cnt, 1);

    // Finder busy after the fill: loader must stall in STRT.
    Fin_idle = 1'b0;
    for (int i = 0; i < 16; i++) d[i] = 8'(8'h21 + i);
    fill(d);
    for (int i = 0; i < 5; i++) begin
      check("stall_strt", {Qw, Qs, Qf}, 3'b010);
      check("stall_start", Start, 0);
      tick();
    end
    Fin_idle = 1'b1;
    #1;
    check("stall_release", Start, 1);
    tick();
    Fin_idle = 1'b0;
    check("stall_wait", {Qw, Qs, Qf}, 3'b100);
    finder_scan(mn, mx);
    check("t3_max", mx, 8'h30);
    check("t3_min", mn, 8'h21);
    check("t3_batch", Batch_cnt, 2);

    d = '{8'h7F, 8'h03, 8'hC8, 8'h40, 8'h55, 8'h10, 8'h99, 8'hA0,
          8'h04, 8'hC7, 8'h20, 8'h33, 8'h66, 8'h77, 8'h88, 8'h12};
    run_batch(d, mn, mx);
    check("t4_max", mx, 8'hC8);
    check("t4_min", mn, 8'h03);
    check("t4_batch", Batch_cnt, 3);

    // Gapped source, then a mid-batch reset.
    for (int k = 0; k < 9; k++) begin
      Din       = 8'(8'hB0 + k);
      Din_valid = 1'b1;
      tick();
      Din_valid = 1'b0;
      tick();
      tick();
    end
    check("gap_count", Count, 9);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_count", Count, 0);
    check("mid_rst_batch", Batch_cnt, 0);
    check("mid_rst_state", {Qw, Qs, Qf}, 3'b001);
    for (int i = 0; i < 16; i++) d[i] = 8'(8'hE0 - 3 * i);
    run_batch(d, mn, mx);
    check("fresh_max", mx, 8'hE0);
    check("fresh_min", mn, 8'hB3);
    check("fresh_batch", Batch_cnt, 1);

    // 255 more batches bring the counter through 255 back to 0.
    for (int b = 0; b < 255; b++) begin
      for (int i = 0; i < 16; i++) d[i] = 8'(b * 16 + i + 1);
      run_batch(d, mn, mx);
      if (b == 253) check("batch_255", Batch_cnt, 255);
    end
    check("batch_wrap", Batch_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
